// File: rtl/gf_div_array.sv
// gf_div_array: back end of the GF element-wise division path.
// Captures an N_ELEM numerator burst plus field definition (deg, poly),
// collects the matching inverse stream, multiplies pairwise in GF(2^deg)
// and streams the quotients out serially.
// Optional build macro GF_DIV_FAST_MUL_EN: one full combinational multiply
// per cycle instead of the bit-serial shift-and-add (results identical).
module gf_div_array #(
    parameter int DATA_W = 5,
    parameter int N_ELEM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        deg,
    input  logic [DATA_W:0]   poly,
    input  logic [DATA_W-1:0] num_data,
    input  logic              inv_valid,
    input  logic [DATA_W-1:0] inv_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);
    localparam int CNT_W = $clog2(N_ELEM + 1);
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ELEM);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, MUL, OUT} state_t;

    state_t                        r_state, w_next;
    logic [2:0]                    r_deg;
    logic [DATA_W:0]               r_poly;
    logic [N_ELEM-1:0][DATA_W-1:0] r_num;
    logic [N_ELEM-1:0][DATA_W-1:0] r_inv;
    logic [CNT_W-1:0]              r_num_cnt, r_inv_cnt, r_out_cnt;
    logic [IDX_W-1:0]              r_elem;
    logic                          r_out_valid, r_busy;
    logic [DATA_W-1:0]             r_out_data;

    logic              w_num_done, w_inv_done, w_mul_last, w_out_done;
    logic [DATA_W-1:0] w_mask;

    // Low-deg bit mask: operand bits at or above deg are not part of the field.
    function automatic logic [DATA_W-1:0] deg_mask(input logic [2:0] d);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(d));
        return m;
    endfunction

    // One MSB-first shift-and-add step: shift, reduce at bit deg, add a if b.
    function automatic logic [DATA_W:0] gf_step(input logic [DATA_W:0]   acc,
                                                 input logic              b,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [2:0]        d,
                                                 input logic [DATA_W:0]   p);
        logic [DATA_W:0] t;
        logic            top;
        t   = {acc[DATA_W-1:0], 1'b0};
        top = 1'b0;
        for (int i = 0; i <= DATA_W; i++) if (i == int'(d)) top = t[i];
        if (top) t = t ^ p;
        if (b)   t = t ^ {1'b0, a};
        return t;
    endfunction

`ifdef GF_DIV_FAST_MUL_EN
    // Full multiply: deg unrolled steps of the same recurrence.
    function automatic logic [DATA_W-1:0] gf_mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [2:0]        d,
                                                 input logic [DATA_W:0]   p);
        logic [DATA_W:0] acc;
        acc = '0;
        for (int k = DATA_W - 1; k >= 0; k--)
            if (k < int'(d)) acc = gf_step(acc, b[k], a, d, p);
        return acc[DATA_W-1:0] & deg_mask(d);
    endfunction

    logic [DATA_W-1:0] w_fast_prod;
    assign w_fast_prod = gf_mul(r_num[r_elem], r_inv[r_elem], r_deg, r_poly);
    assign w_mul_last  = (r_elem == IDX_LAST);
`else
    logic [DATA_W:0]   r_acc;
    logic [2:0]        r_bit;
    logic [DATA_W-1:0] w_inv_row;
    logic [DATA_W:0]   w_step;
    assign w_inv_row  = r_inv[r_elem];
    assign w_step     = gf_step(r_acc, w_inv_row[r_bit], r_num[r_elem], r_deg, r_poly);
    assign w_mul_last = (r_bit == 3'd0) && (r_elem == IDX_LAST);
`endif

    // A stream is complete once its counter is full or its last beat is arriving now.
    assign w_num_done = (r_num_cnt == CNT_FULL) || (in_valid  && r_num_cnt == CNT_PRE);
    assign w_inv_done = (r_inv_cnt == CNT_FULL) || (inv_valid && r_inv_cnt == CNT_PRE);
    assign w_out_done = (r_out_cnt == CNT_FULL);
    assign w_mask     = deg_mask(r_deg);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = COLLECT;
            COLLECT: if (w_num_done && w_inv_done) w_next = MUL;
            MUL:     if (w_mul_last) w_next = OUT;
            OUT:     if (w_out_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture, multiply in place, then stream results out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deg       <= '0;
            r_poly      <= '0;
            r_num       <= '0;
            r_inv       <= '0;
            r_num_cnt   <= '0;
            r_inv_cnt   <= '0;
            r_out_cnt   <= '0;
            r_elem      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
`ifndef GF_DIV_FAST_MUL_EN
            r_acc       <= '0;
            r_bit       <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_deg     <= deg;
                        r_poly    <= poly;
                        r_num[0]  <= num_data & deg_mask(deg);
                        r_num_cnt <= CNT_W'(1);
                        r_inv_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (in_valid && r_num_cnt != CNT_FULL) begin
                        r_num[r_num_cnt[IDX_W-1:0]] <= num_data & w_mask;
                        r_num_cnt <= r_num_cnt + 1'b1;
                    end
                    if (inv_valid && r_inv_cnt != CNT_FULL) begin
                        r_inv[r_inv_cnt[IDX_W-1:0]] <= inv_data & w_mask;
                        r_inv_cnt <= r_inv_cnt + 1'b1;
                    end
                    if (w_num_done && w_inv_done) begin
                        r_elem    <= '0;
                        r_out_cnt <= '0;
`ifndef GF_DIV_FAST_MUL_EN
                        r_acc     <= '0;
                        r_bit     <= r_deg - 3'd1;
`endif
                    end
                end
                MUL: begin
`ifdef GF_DIV_FAST_MUL_EN
                    r_num[r_elem] <= w_fast_prod;
                    if (r_elem != IDX_LAST) r_elem <= r_elem + 1'b1;
`else
                    if (r_bit == 3'd0) begin
                        r_num[r_elem] <= w_step[DATA_W-1:0] & w_mask;
                        r_acc         <= '0;
                        r_bit         <= r_deg - 3'd1;
                        if (r_elem != IDX_LAST) r_elem <= r_elem + 1'b1;
                    end else begin
                        r_acc <= w_step;
                        r_bit <= r_bit - 3'd1;
                    end
`endif
                end
                OUT: begin
                    // Extra terminal cycle keeps busy high through the last beat.
                    if (!w_out_done) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_num[r_out_cnt[IDX_W-1:0]];
                        r_out_cnt   <= r_out_cnt + 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
endmodule

// File: tb/tb_gf_div_array.sv
// tb_gf_div_array: directed vectors with a scoreboard queue; the driver
// pushes expected quotients and their expected cycle, the monitor pops
// and compares whenever out_valid is seen.
`timescale 1ns/1ps
module tb_gf_div_array;
    localparam int DW = 5;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [2:0]    deg = '0;
    logic [DW:0]   poly = '0;
    logic [DW-1:0] num_data = '0;
    logic          inv_valid = 1'b0;
    logic [DW-1:0] inv_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;

    gf_div_array #(.DATA_W(DW), .N_ELEM(NE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .deg(deg), .poly(poly),
        .num_data(num_data), .inv_valid(inv_valid), .inv_data(inv_data),
        .out_valid(out_valid), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [DW-1:0] v_num[4];
    logic [DW-1:0] v_inv[5];
    logic [DW-1:0] v_exp[4];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop expected quotient on every out_valid cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                check("out_in_overlap", int'(in_valid), 0);
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", int'(out_data), int'(mon_e.data));
                    check("out_cycle", cyc, mon_e.at);
                end
            end else begin
                check("out_data_idle", int'(out_data), 0);
            end
        end
    end

    // Drive one burst; inverse stream starts idly cycles after the first
    // numerator beat and carries ninv beats. Called/returns at #1 after a posedge.
    task automatic burst(input int d, input int p, input int ninv, input int idly, input bit push);
        int c0, tl, tend, lat, e;
        tl   = (idly + 3 > 3) ? idly + 3 : 3;
        tend = (idly + ninv - 1 > 3) ? idly + ninv - 1 : 3;
`ifdef GF_DIV_FAST_MUL_EN
        lat = 5;
`else
        lat = 4 * d + 1;
`endif
        for (int t = 0; t <= tend; t++) begin
            in_valid  = (t < 4);
            deg       = (t == 0) ? 3'(d) : 3'd0;
            poly      = (t == 0) ? 6'(p) : 6'd0;
            num_data  = (t < 4) ? v_num[t] : '0;
            inv_valid = (t >= idly) && (t < idly + ninv);
            inv_data  = inv_valid ? v_inv[t - idly] : '0;
            if (t == 0) begin
                c0 = cyc;
                e  = c0 + tl + 1;
                if (push) for (int i = 0; i < 4; i++) sb.push_back('{data: v_exp[i], at: e + lat + i});
            end
            @(posedge clk); #1;
            if (t == 0) check("busy_after_accept", int'(busy), 1);
        end
        in_valid  = 1'b0;
        inv_valid = 1'b0;
        num_data  = '0;
        inv_data  = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("busy_timeout", 1, 0);
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        gap(2);

        // deg 4, x^4+x+1
        v_num = '{1, 3, 0, 5}; v_inv = '{9, 9, 7, 1, 0}; v_exp = '{9, 8, 0, 5};
        burst(4, 19, 4, 1, 1'b1);
        wait_idle(); gap(2);

        // deg 2, x^2+x+1, inverse stream lags the numerators
        v_num = '{2, 1, 3, 0}; v_inv = '{2, 3, 2, 1, 0}; v_exp = '{3, 3, 1, 0};
        burst(2, 7, 4, 2, 1'b1);
        wait_idle(); gap(2);

        // deg 5, x^5+x^2+1, reduction from the top bit
        v_num = '{16, 1, 31, 0}; v_inv = '{2, 1, 1, 31, 0}; v_exp = '{5, 1, 31, 0};
        burst(5, 37, 4, 1, 1'b1);
        wait_idle(); gap(2);

        // upper operand bits masked, 5th inverse beat ignored
        v_num = '{5'b11101, 5'b00110, 5'b11111, 5'b01000};
        v_inv = '{5'b11110, 5'b11110, 5'b11110, 5'b11110, 5'b00011};
        v_exp = '{2, 3, 1, 0};
        burst(2, 7, 5, 1, 1'b1);
        wait_idle(); gap(2);

        // reset while multiplying discards the burst
        v_num = '{1, 3, 0, 5}; v_inv = '{9, 9, 7, 1, 0};
        burst(4, 19, 4, 1, 1'b0);
        gap(1);
        check("busy_in_mul", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        gap(1);
        v_num = '{1, 1, 1, 1}; v_inv = '{9, 9, 9, 9, 0}; v_exp = '{9, 9, 9, 9};
        burst(4, 19, 4, 1, 1'b1);
        wait_idle(); gap(2);

        // back-to-back: second burst starts on first busy-low cycle
        v_num = '{2, 1, 3, 0}; v_inv = '{2, 3, 2, 1, 0}; v_exp = '{3, 3, 1, 0};
        burst(2, 7, 4, 1, 1'b1);
        wait_idle();
        v_num = '{1, 3, 0, 5}; v_inv = '{9, 9, 7, 1, 0}; v_exp = '{9, 8, 0, 5};
        burst(4, 19, 4, 3, 1'b1);
        wait_idle(); gap(3);

        begin
            int n;
            n = 0;
            while (sb.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
            if (sb.size() > 0) check("missing_outputs", sb.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
